pemstat_sched: RTL

- Scheduler and owner of the MAC statistics counter bank.
- Accepts increment requests from up to NUM_REQ event sources (TX/RX stat engines) and host read/write accesses.
- Round-robin arbitrates them onto one shared 24-bit add datapath: a 3-stage pipeline (arbitrate, read, add/write) with forwarding.
- Maintains per-counter sticky overflow flags and supports clear-on-read for the host register interface.

---
 rtl/pemstat_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pemstat_sched.sv
// pemstat_sched: owner of the MAC statistics counter bank.
// Round-robin schedules requester increments and host read/write accesses
// onto one shared add datapath (arbitrate -> read -> add/write), forwarding
// the S2 write value into S1 so back-to-back ops on one index stay exact.
module pemstat_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_AW  = 4,
  parameter int CNT_W   = 24,
  parameter int INC_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CNT_AW-1:0] req_idx,
  input  logic [NUM_REQ*INC_W-1:0]  req_inc,
  input  logic                      host_rd,
  input  logic                      host_wr,
  input  logic [CNT_AW-1:0]         host_idx,
  input  logic [30:0]               host_wdata,
  input  logic                      rd_clr_en,
  output logic                      host_ack,
  output logic [30:0]               host_rdata,
  output logic [2**CNT_AW-1:0]      ovf,
  input  logic                      ovf_clr,
  input  logic [CNT_AW-1:0]         ovf_clr_idx
);

  localparam int NUM_CNT = 2**CNT_AW;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    OP_INC = 2'd0,
    OP_RD  = 2'd1,
    OP_WR  = 2'd2
  } op_e;

  logic [PTR_W-1:0]   rr_ptr;
  logic               host_busy;
  logic               host_go;
  logic [NUM_REQ-1:0] req_rot;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_off;
  logic [PTR_W-1:0]   grant_id;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W:0]     win_sum;
  logic [PTR_W:0]     nxt_sum;

  logic               a_valid;
  op_e                a_op;
  logic [CNT_AW-1:0]  a_idx;
  logic [CNT_W-1:0]   a_opnd;

  logic               s1_valid;
  op_e                s1_op;
  logic [CNT_AW-1:0]  s1_idx;
  logic [CNT_W-1:0]   s1_opnd;
  logic [CNT_W-1:0]   s1_old;

  logic               s2_valid;
  op_e                s2_op;
  logic [CNT_AW-1:0]  s2_idx;
  logic [CNT_W-1:0]   s2_opnd;
  logic [CNT_W-1:0]   s2_old;
  logic [CNT_W:0]     s2_sum;
  logic [CNT_W-1:0]   s2_wval;

  logic [CNT_W-1:0]   cnt [NUM_CNT];

  // Upper load bits are don't-care for a 24-bit counter.
  logic host_wdata_unused;
  assign host_wdata_unused = ^host_wdata[30:CNT_W];

  assign host_go = (host_rd | host_wr) & ~host_busy;

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the lowest set bit.
  always_comb begin
    req_rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    grant_any = 1'b0;
    grant_off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_any = 1'b1;
        grant_off = PTR_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (win_sum >= NREQ) win_sum = win_sum - NREQ;
    grant_id = win_sum[PTR_W-1:0];
    nxt_sum  = win_sum + (PTR_W+1)'(1);
    if (nxt_sum >= NREQ) nxt_sum = nxt_sum - NREQ;
    ptr_next = nxt_sum[PTR_W-1:0];
  end

  // Stage A issue mux: host first, then the round-robin winner, else a bubble.
  always_comb begin
    req_ready = '0;
    a_valid   = 1'b0;
    a_op      = OP_INC;
    a_idx     = '0;
    a_opnd    = '0;
    if (host_go) begin
      a_valid = 1'b1;
      a_op    = host_rd ? OP_RD : OP_WR;
      a_idx   = host_idx;
      a_opnd  = host_wdata[CNT_W-1:0];
    end else if (grant_any) begin
      a_valid = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_id == PTR_W'(k)) begin
          req_ready[k] = ~reset;
          a_idx        = req_idx[k*CNT_AW +: CNT_AW];
          a_opnd       = CNT_W'(req_inc[k*INC_W +: INC_W]);
        end
      end
    end
  end

  // Issue register, RR pointer and host busy flag (held through the ack cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_INC;
      s1_idx    <= '0;
      s1_opnd   <= '0;
      rr_ptr    <= '0;
      host_busy <= 1'b0;
    end else begin
      s1_valid <= a_valid;
      s1_op    <= a_op;
      s1_idx   <= a_idx;
      s1_opnd  <= a_opnd;
      if (!host_go && grant_any) rr_ptr <= ptr_next;
      if (host_go) host_busy <= 1'b1;
      else if (host_ack) host_busy <= 1'b0;
    end
  end

  // S1 read with bypass of the value S2 is writing this cycle.
  always_comb begin
    s1_old = cnt[s1_idx];
    if (s2_valid && (s2_idx == s1_idx)) s1_old = s2_wval;
  end

  // S1 -> S2 pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_op    <= OP_INC;
      s2_idx   <= '0;
      s2_opnd  <= '0;
      s2_old   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_idx   <= s1_idx;
      s2_opnd  <= s1_opnd;
      s2_old   <= s1_old;
    end
  end

  // S2 result: wrapped sum for increments, clear/keep for reads, load for writes.
  always_comb begin
    s2_sum = {1'b0, s2_old} + {1'b0, s2_opnd};
    case (s2_op)
      OP_INC:  s2_wval = s2_sum[CNT_W-1:0];
      OP_RD:   s2_wval = rd_clr_en ? '0 : s2_old;
      default: s2_wval = s2_opnd;
    endcase
  end

  // Counter writeback, read data capture and host completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      if (s2_valid) cnt[s2_idx] <= s2_wval;
      host_ack <= s2_valid && (s2_op != OP_INC);
      if (s2_valid && (s2_op == OP_RD)) host_rdata <= 31'(s2_old);
    end
  end

  // Sticky overflow flags; a clear on the same index as a new overflow wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= '0;
    end else begin
      if (s2_valid && (s2_op == OP_INC) && s2_sum[CNT_W]) ovf[s2_idx] <= 1'b1;
      if (ovf_clr) ovf[ovf_clr_idx] <= 1'b0;
    end
  end

endmodule
